// File: rtl/fuzzy_operand_seq_pkg.sv
// Shared definitions for the fuzzy operand sequencer and fuzzy evaluator:
// FSM state encodings, operator codes and the default membership width.
package fuzzy_operand_seq_pkg;

    localparam int unsigned FUZZY_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_EVAL    = 3'd3,
        S_HOLD    = 3'd4
    } state_e;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_NOT  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

endpackage

// File: rtl/fuzzy_eval.sv
// Combinational fuzzy operator: AND = min, OR = max, NOT = complement of a.
// Reserved operator code yields zero.
module fuzzy_eval
    import fuzzy_operand_seq_pkg::*;
#(
    parameter int unsigned WIDTH = FUZZY_WIDTH
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:  y_o = (a_i < b_i) ? a_i : b_i;
            OP_OR:   y_o = (a_i > b_i) ? a_i : b_i;
            OP_NOT:  y_o = ~a_i;
            OP_RSVD: y_o = '0;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/fuzzy_operand_seq.sv
// Sequencer around a shared 2:1 operand mux: fetches A (sel=0) then B (sel=1),
// evaluates the fuzzy operator and holds the result under valid/ready.
module fuzzy_operand_seq
    import fuzzy_operand_seq_pkg::*;
#(
    parameter int unsigned WIDTH = FUZZY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             sel,
    input  logic [WIDTH-1:0] mux_res,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    input  logic             ready,
    output logic             busy
);

    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_d;

    fuzzy_eval #(
        .WIDTH(WIDTH)
    ) u_eval (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (result_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        state_q <= S_FETCH_A;
                    end
                end
                S_FETCH_A: begin
                    a_q     <= mux_res;
                    // NOT needs only operand A, so the B fetch is skipped
                    state_q <= (op_q == OP_NOT) ? S_EVAL : S_FETCH_B;
                end
                S_FETCH_B: begin
                    b_q     <= mux_res;
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    result_q <= result_d;
                    valid_q  <= 1'b1;
                    state_q  <= S_HOLD;
                end
                S_HOLD: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // sel decodes state only, so the upstream mux sees a stable select all cycle
    assign sel    = (state_q == S_FETCH_B);
    assign busy   = (state_q != S_IDLE);
    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_fuzzy_operand_seq.sv
// Directed self-checking bench for fuzzy_operand_seq with a behavioural
// operand mux driven from sel.
module tb_fuzzy_operand_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic       sel;
    logic [7:0] mux_res;
    logic [7:0] result;
    logic       valid;
    logic       ready;
    logic       busy;

    logic [7:0] a_val;
    logic [7:0] b_val;
    logic       mux_x;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign mux_res = mux_x ? 8'hxx : (sel ? b_val : a_val);

    fuzzy_operand_seq #(
        .WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .sel     (sel),
        .mux_res (mux_res),
        .result  (result),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'd0; ready = 1'b0;
        a_val = 8'h00; b_val = 8'h00; mux_x = 1'b0;
        #2;
        total++;
        if ({sel, valid, busy, result} !== 11'd0) $display("FAIL reset_outputs: sel=%b valid=%b busy=%b result=%h, expected all 0", sel, valid, busy, result);
        else passed++;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        total++;
        if ({busy, valid} !== 2'b00) $display("FAIL reset_idle: busy=%b valid=%b, expected 0 0", busy, valid);
        else passed++;
    endtask

    task automatic test_and();
        a_val = 8'h9C; b_val = 8'h41; ready = 1'b1;
        start = 1'b1; op = 2'd0;
        tick();                         // edge k
        start = 1'b0;
        total++;
        if ({sel, busy} !== 2'b01) $display("FAIL and_fetch_a: sel=%b busy=%b, expected sel=0 busy=1", sel, busy);
        else passed++;
        tick();                         // edge k+1
        total++;
        if (sel !== 1'b1) $display("FAIL and_fetch_b_sel: sel=%b, expected 1", sel);
        else passed++;
        tick();                         // edge k+2 -> EVAL; mux output no longer relevant
        mux_x = 1'b1;
        total++;
        if ({sel, valid} !== 2'b00) $display("FAIL and_eval: sel=%b valid=%b, expected 0 0", sel, valid);
        else passed++;
        tick();                         // edge k+3
        total++;
        if (valid !== 1'b1 || result !== 8'h41) $display("FAIL and_result: valid=%b result=%h, expected valid=1 result=41", valid, result);
        else passed++;
        tick();                         // accepted at k+4
        total++;
        if ({valid, busy} !== 2'b00 || result !== 8'h41) $display("FAIL and_accept: valid=%b busy=%b result=%h, expected 0 0 41", valid, busy, result);
        else passed++;
        mux_x = 1'b0;
    endtask

    task automatic test_or_stall();
        a_val = 8'h9C; b_val = 8'h41; ready = 1'b0;
        start = 1'b1; op = 2'd1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();         // edge k+3
        total++;
        if (valid !== 1'b1 || result !== 8'h9C) $display("FAIL or_result: valid=%b result=%h, expected valid=1 result=9c", valid, result);
        else passed++;
        a_val = 8'h11; b_val = 8'h22;   // changing mux output while holding
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (valid !== 1'b1 || result !== 8'h9C || busy !== 1'b1) $display("FAIL or_stall%0d: valid=%b result=%h busy=%b, expected 1 9c 1", i, valid, result, busy);
            else passed++;
        end
        ready = 1'b1;
        tick();
        total++;
        if ({valid, busy} !== 2'b00) $display("FAIL or_accept: valid=%b busy=%b, expected 0 0", valid, busy);
        else passed++;
    endtask

    task automatic test_not();
        a_val = 8'h30; b_val = 8'hAA; ready = 1'b0;
        start = 1'b1; op = 2'd2;
        tick();                         // edge k
        start = 1'b0;
        total++;
        if ({sel, busy} !== 2'b01) $display("FAIL not_fetch_a: sel=%b busy=%b, expected 0 1", sel, busy);
        else passed++;
        tick();                         // edge k+1 -> EVAL
        total++;
        if ({sel, valid} !== 2'b00) $display("FAIL not_eval: sel=%b valid=%b, expected 0 0", sel, valid);
        else passed++;
        tick();                         // edge k+2
        total++;
        if (valid !== 1'b1 || result !== 8'hCF || sel !== 1'b0) $display("FAIL not_result: valid=%b result=%h sel=%b, expected 1 cf 0", valid, result, sel);
        else passed++;
        ready = 1'b1;
        tick();
        total++;
        if ({valid, busy} !== 2'b00) $display("FAIL not_accept: valid=%b busy=%b, expected 0 0", valid, busy);
        else passed++;
    endtask

    task automatic test_boundaries();
        logic [1:0] ops  [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
        logic [7:0] as   [4] = '{8'hFF, 8'h00, 8'h5A, 8'h77};
        logic [7:0] bs   [4] = '{8'hFF, 8'hFF, 8'hA5, 8'h77};
        logic [7:0] exps [4] = '{8'hFF, 8'hFF, 8'h00, 8'h77};
        int n;
        for (int v = 0; v < 4; v++) begin
            a_val = as[v]; b_val = bs[v]; op = ops[v]; ready = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 1;
            while (valid !== 1'b1 && n < 12) begin
                tick();
                n++;
            end
            total++;
            if (valid !== 1'b1 || n != 4 || result !== exps[v]) $display("FAIL boundary%0d: valid=%b latency=%0d result=%h, expected 1 4 %h", v, valid, n, result, exps[v]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_handshake_start();
        a_val = 8'h12; b_val = 8'h34; ready = 1'b0; op = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();         // in HOLD
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({valid, busy} !== 2'b00 || result !== 8'h34) $display("FAIL hold_start_ready: valid=%b busy=%b result=%h, expected 0 0 34", valid, busy, result);
        else passed++;
        tick();
        total++;
        if (busy !== 1'b0) $display("FAIL hold_start_ignored: busy=%b, expected 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int cnt;
        int first;
        int last;
        int gap_bad;
        a_val = 8'h9C; b_val = 8'h41; op = 2'd0; ready = 1'b1;
        start = 1'b1;
        cnt = 0; first = -1; last = -1; gap_bad = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (valid === 1'b1) begin
                if (last >= 0 && e - last != 5) gap_bad++;
                if (first < 0) first = e;
                last = e;
                cnt++;
            end
        end
        start = 1'b0;
        total++;
        if (cnt != 3 || first != 4 || gap_bad != 0) $display("FAIL back_to_back: results=%0d first=%0d gap_errors=%0d, expected 3 4 0", cnt, first, gap_bad);
        else passed++;
        for (int i = 0; i < 12 && busy === 1'b1; i++) tick();
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_drain: busy=%b, expected 0", busy);
        else passed++;

        // start pulsed during FETCH_B must not spawn a second operation
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        for (int e = 0; e < 12; e++) begin
            if (valid === 1'b1) cnt++;
            tick();
        end
        total++;
        if (cnt != 1 || busy !== 1'b0) $display("FAIL start_in_fetch_b: results=%0d busy=%b, expected 1 0", cnt, busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        a_val = 8'h9C; b_val = 8'h41; op = 2'd0; ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();                         // FETCH_B
        rst = 1'b1;
        #1;
        total++;
        if ({valid, busy, sel} !== 3'b000) $display("FAIL reset_fetch_b: valid=%b busy=%b sel=%b, expected 0 0 0", valid, busy, sel);
        else passed++;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();         // HOLD with valid high
        rst = 1'b1;
        #1;
        total++;
        if ({valid, busy} !== 2'b00 || result !== 8'h00) $display("FAIL reset_hold: valid=%b busy=%b result=%h, expected 0 0 00", valid, busy, result);
        else passed++;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        total++;
        if ({valid, busy} !== 2'b00) $display("FAIL reset_release_idle: valid=%b busy=%b, expected 0 0", valid, busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_and();
        test_or_stall();
        test_not();
        test_boundaries();
        test_handshake_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fuzzy_operand_seq.md
Name: fuzzy_operand_seq

Overview:
- Sequencer sitting directly around the 2:1 operand select mux: drives the mux `sel`, captures the mux output over two cycles (operand A on sel=0, operand B on sel=1), then evaluates the fuzzy operator and presents the result downstream.
- Fuzzy operators: AND = min, OR = max, NOT-A = complement of A.
- Result is held under a valid/ready handshake, so one shared mux serves both operands of the fuzzy ALU.

Parameters:
- WIDTH, 8, membership-value width; all values are unsigned, 0 = none, 2^WIDTH-1 = full membership.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  operator: 0 = AND(min), 1 = OR(max), 2 = NOT(A), 3 = reserved; latched with start
- sel  out  1  select to the operand mux (0 selects operand A, 1 selects operand B)
- mux_res  in  WIDTH  operand mux output; combinational from sel
- result  out  WIDTH  fuzzy result, registered
- valid  out  1  result valid; held until accepted
- ready  in  1  downstream accept
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high, independent of clk):
  - state = IDLE, sel = 0, result = 0, valid = 0, busy = 0.
  - Internal op_q, a_q and b_q are cleared to 0.
- States: IDLE, FETCH_A, FETCH_B, EVAL, HOLD. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - sel = 0.
  - start = 1 at edge k: op_q <= op; next state FETCH_A.
- FETCH_A:
  - sel = 0.
  - At the end of the cycle, a_q <= mux_res.
  - op_q = NOT: next state EVAL (the B fetch is skipped). Otherwise: next state FETCH_B.
- FETCH_B:
  - sel = 1.
  - At the end of the cycle, b_q <= mux_res; next state EVAL.
- EVAL:
  - sel = 0.
  - result <= min(a_q, b_q) for AND; max(a_q, b_q) for OR; ~a_q for NOT; 0 for reserved.
  - valid <= 1; next state HOLD.
- HOLD:
  - valid = 1; result is stable.
  - ready = 1: valid <= 0 at that edge; next state IDLE.
  - start is ignored in HOLD, and while busy generally.
- Latency (start accepted at edge k):
  - AND/OR: valid is high after edge k+3.
  - NOT: valid is high after edge k+2.
  - Minimum initiation interval is 5 cycles for AND/OR: IDLE, A, B, EVAL, HOLD with ready already high.
- `sel` is a decoded state output, so it is glitch-free and stable for the whole fetch cycle. The upstream mux has a full cycle to settle.
- Comparisons are unsigned, WIDTH bits. Equal operands yield that value for both min and max.
- Boundaries:
  - ready held low: HOLD persists indefinitely; result and valid do not change.
  - ready high in the same cycle valid first rises: no effect; acceptance happens only in HOLD.
  - start and ready both high in HOLD: complete the handshake only. The new start must be re-presented in IDLE.
  - Reset mid-operation (any state): immediate return to IDLE; valid drops asynchronously; the partial operand is discarded.
  - mux_res is X or changing outside FETCH_A/FETCH_B: must not affect any state.

Decomposition:
- Shared package/include `fuzzy_defs`:
  - state encodings S_IDLE..S_HOLD (3-bit).
  - operator codes OP_AND=2'd0, OP_OR=2'd1, OP_NOT=2'd2.
  - default membership width.
- One natural sub-module: `fuzzy_eval` (combinational min/max/complement of two WIDTH-bit values selected by op). It is reused by the later fuzzy ALU. The FSM and registers stay in fuzzy_operand_seq.
- The 2:1 mux is instantiated by the parent, not inside this block.

Test Plan:
- Reset check: assert rst mid-FETCH_B → same cycle valid=0, busy=0, sel=0. After release, the block idles until start.
- AND: WIDTH=8, mux returns 8'h9C when sel=0 and 8'h41 when sel=1, op=0, ready=1 → sel sequence 0,1 on cycles k+1, k+2; result=8'h41, valid high after edge k+3 for exactly one cycle.
- OR: same operands, op=1, ready low for 4 cycles then high → result=8'h9C; valid and result stable for all 4 stall cycles; valid drops on the accept edge.
- NOT: a=8'h30, op=2 → sel never goes to 1; result=8'hCF; valid high after edge k+2.
- Boundaries: a=b=8'hFF with AND gives 8'hFF; a=8'h00, b=8'hFF with OR gives 8'hFF; reserved op=3 gives result=8'h00.
- Back-to-back with handshake interference: start held high continuously with ready=1 → a new operation begins only from IDLE, every 5 cycles. start pulsed during FETCH_B → ignored, no second result.
